// File: rtl/prio_q_nway.sv
`default_nettype none
// ============================================================================
// prio_q_nway : N-way min-priority queue over parallel sorted heaps with a
//               registered global-minimum output stage.        Rev 1.0
// ============================================================================

module pheap #(
  parameter int WIDTH   = 32,
  parameter int CMP_WID = 32,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] inp_data,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] elem_cnt
);
  localparam int c_cap = (1 << DEPTH) - 1;

  logic [WIDTH-1:0] r_mem [c_cap];
  logic [WIDTH-1:0] w_ins [c_cap];
  logic [WIDTH-1:0] w_pop [c_cap];
  logic [c_cap-1:0] w_le;
  logic [DEPTH-1:0] r_cnt;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_cnt == DEPTH'(c_cap));
  assign w_empty = (r_cnt == '0);

  // Storage is kept sorted; an insert lands after every entry with a key <= its own.
  always_comb begin
    for (int i = 0; i < c_cap; i++)
      w_le[i] = (DEPTH'(i) < r_cnt) && (r_mem[i][CMP_WID-1:0] <= inp_data[CMP_WID-1:0]);
    w_ins[0] = w_le[0] ? r_mem[0] : inp_data;
    for (int i = 1; i < c_cap; i++)
      w_ins[i] = w_le[i] ? r_mem[i] : (w_le[i-1] ? inp_data : r_mem[i-1]);
    for (int i = 0; i < c_cap - 1; i++)
      w_pop[i] = r_mem[i+1];
    w_pop[c_cap-1] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < c_cap; i++)
        r_mem[i] <= '0;
    end else if (enq && !w_full) begin
      r_mem <= w_ins;
      r_cnt <= r_cnt + DEPTH'(1);
    end else if (deq && !w_empty) begin
      r_mem <= w_pop;
      r_cnt <= r_cnt - DEPTH'(1);
    end
  end

  assign out_data = r_mem[0];
  assign elem_cnt = r_cnt;
endmodule

module prio_q_nway #(
  parameter int WIDTH    = 32,
  parameter int CMP_WID  = 32,
  parameter int DEPTH    = 8,
  parameter int NUM_HEAP = 4,
  parameter int HEAP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] inp_data,
  input  logic             deq,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [DEPTH+3:0] elem_cnt,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);
  localparam int             c_cap     = (1 << DEPTH) - 1;
  localparam int             c_hw      = $clog2(NUM_HEAP);
  localparam logic [2:0]     c_lat     = 3'(HEAP_LAT);
  localparam logic [DEPTH+3:0] c_one   = 1;
  localparam logic [1:0]     c_s_empty = 2'd0;
  localparam logic [1:0]     c_s_wait  = 2'd1;
  localparam logic [1:0]     c_s_pick  = 2'd2;
  localparam logic [1:0]     c_s_hold  = 2'd3;

  logic [1:0]          r_state;
  logic [2:0]          r_cnt;
  logic [WIDTH-1:0]    r_out;
  logic [DEPTH+3:0]    r_elem;
  logic                r_ovf;
  logic                r_udf;

  logic [WIDTH-1:0]    w_head [NUM_HEAP];
  logic [DEPTH-1:0]    w_hcnt [NUM_HEAP];
  logic [NUM_HEAP-1:0] w_henq;
  logic [NUM_HEAP-1:0] w_hdeq;
  logic [WIDTH-1:0]    w_hin;
  logic [WIDTH-1:0]    w_cur;
  logic [c_hw-1:0]     w_sel;
  logic [c_hw-1:0]     w_tgt;
  logic                w_any;
  logic                w_tgt_ok;
  logic                w_enq_ok;
  logic                w_deq_ok;
  logic                w_swap;

  function automatic logic [CMP_WID-1:0] key(input logic [WIDTH-1:0] d);
    return d[CMP_WID-1:0];
  endfunction

  // Head select: smallest key among non-empty heaps, strict compare keeps lowest index on ties.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = 0; i < NUM_HEAP; i++) begin
      if (w_hcnt[i] != '0 && (!w_any || key(w_head[i]) < key(w_head[w_sel]))) begin
        w_sel = c_hw'(i);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_tgt    = '0;
    w_tgt_ok = 1'b0;
    for (int i = 0; i < NUM_HEAP; i++) begin
      if (w_hcnt[i] != DEPTH'(c_cap) && !(r_state == c_s_pick && w_sel == c_hw'(i)) &&
          (!w_tgt_ok || w_hcnt[i] < w_hcnt[w_tgt])) begin
        w_tgt    = c_hw'(i);
        w_tgt_ok = 1'b1;
      end
    end
  end

  assign w_enq_ok = enq && w_tgt_ok;
  assign w_deq_ok = deq && (r_state == c_s_hold);

  // A smaller incoming key displaces the outgoing entry, which is recycled into a heap.
  // PICK gets the same treatment so the output never misses a same-cycle smaller arrival.
  assign w_cur  = (r_state == c_s_pick) ? w_head[w_sel] : r_out;
  assign w_swap = (r_state == c_s_pick || r_state == c_s_hold) && w_enq_ok && !w_deq_ok &&
                  (key(inp_data) < key(w_cur));

  always_comb begin
    w_henq = '0;
    w_hdeq = '0;
    w_hin  = w_swap ? w_cur : inp_data;
    if (r_state == c_s_pick) w_hdeq[w_sel] = 1'b1;
    if (w_enq_ok)            w_henq[w_tgt] = 1'b1;
  end

  for (genvar g = 0; g < NUM_HEAP; g++) begin : g_heap
    pheap #(
      .WIDTH   (WIDTH),
      .CMP_WID (CMP_WID),
      .DEPTH   (DEPTH)
    ) u_heap (
      .clk      (clk),
      .rst_n    (rst_n),
      .enq      (w_henq[g]),
      .deq      (w_hdeq[g]),
      .inp_data (w_hin),
      .out_data (w_head[g]),
      .elem_cnt (w_hcnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_s_empty;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        c_s_empty: begin
          if (w_enq_ok) begin
            r_state <= c_s_wait;
            r_cnt   <= c_lat;
          end
        end
        c_s_wait: begin
          if (w_enq_ok) begin
            r_cnt <= c_lat;
          end else if (r_cnt > 3'd1) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_cnt   <= '0;
            r_state <= w_any ? c_s_pick : c_s_empty;
          end
        end
        c_s_pick: begin
          r_out   <= w_swap ? inp_data : w_head[w_sel];
          r_state <= c_s_hold;
        end
        default: begin
          if (w_deq_ok) begin
            r_state <= (w_any || w_enq_ok) ? c_s_wait : c_s_empty;
            r_cnt   <= (w_any || w_enq_ok) ? c_lat : 3'd0;
          end else if (w_swap) begin
            r_out <= inp_data;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_enq_ok && !w_deq_ok)      r_elem <= r_elem + c_one;
      else if (w_deq_ok && !w_enq_ok) r_elem <= r_elem - c_one;
      if (enq && !w_tgt_ok)           r_ovf  <= 1'b1;
      if (deq && r_state != c_s_hold) r_udf  <= 1'b1;
    end
  end

  assign out_data  = r_out;
  assign out_valid = (r_state == c_s_hold);
  assign elem_cnt  = r_elem;
  assign full      = !w_tgt_ok;
  assign empty     = (r_elem == '0);
  assign err_ovf   = r_ovf;
  assign err_udf   = r_udf;
endmodule
`default_nettype wire

// File: tb/tb_prio_q_nway.sv
`default_nettype none
// tb_prio_q_nway: cycle table, corner sequences and a randomized multiset model for prio_q_nway.
module tb_prio_q_nway;
  localparam int W = 16, CW = 8, D = 2, NH = 2, LAT = 1;

  logic           clk, rst_n, enq, deq;
  logic [W-1:0]   inp_data, out_data;
  logic           out_valid, full, empty, err_ovf, err_udf;
  logic [D+3:0]   elem_cnt;
  int             n_tests = 0;
  int             n_fail = 0;

  typedef struct {
    bit          f_enq;
    logic [15:0] f_din;
    bit          f_deq;
    bit          x_valid;
    logic [15:0] x_data;
    int          x_cnt;
  } vec_t;
  vec_t tbl[$];

  prio_q_nway #(.WIDTH(W), .CMP_WID(CW), .DEPTH(D), .NUM_HEAP(NH), .HEAP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .inp_data(inp_data), .deq(deq),
    .out_data(out_data), .out_valid(out_valid), .elem_cnt(elem_cnt), .full(full),
    .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enq = 1'b0; deq = 1'b0; inp_data = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [15:0] d);
    enq = 1'b1; inp_data = d;
    tick();
    enq = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (!out_valid && i < 20) begin
      tick();
      i++;
    end
    if (!out_valid) chk({name, " timeout"}, out_valid, 1);
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    wait_valid(name);
    chk(name, out_data, exp);
    deq = 1'b1;
    tick();
    deq = 1'b0;
  endtask

  // Enqueue into an empty queue: valid exactly HEAP_LAT+2 cycles later.
  task automatic t_latency(input string tag);
    push(16'h0005);
    chk({tag, " cnt@1"}, elem_cnt, 1);
    chk({tag, " valid@1"}, out_valid, 0);
    tick();
    chk({tag, " valid@2"}, out_valid, 0);
    tick();
    chk({tag, " valid@3"}, out_valid, 1);
    chk({tag, " data@3"}, out_data, 16'h0005);
    deq = 1'b1; tick(); deq = 1'b0;
    chk({tag, " empty after pop"}, empty, 1);
  endtask

  function automatic vec_t mk(input bit e, input logic [15:0] d, input bit q,
                              input bit v, input logic [15:0] xd, input int c);
    vec_t t;
    t.f_enq = e; t.f_din = d; t.f_deq = q; t.x_valid = v; t.x_data = xd; t.x_cnt = c;
    return t;
  endfunction

  function automatic int min_idx(input logic [15:0] q[$]);
    int m = -1;
    for (int i = 0; i < q.size(); i++)
      if (m < 0 || q[i][7:0] < q[m][7:0]) m = i;
    return m;
  endfunction

  initial begin
    // Back-to-back 9,3,7,3,1 then drain: one row per cycle.
    tbl.push_back(mk(1, 16'd9, 0, 0, 16'd0, 0));
    tbl.push_back(mk(1, 16'd3, 0, 0, 16'd0, 1));
    tbl.push_back(mk(1, 16'd7, 0, 0, 16'd0, 2));
    tbl.push_back(mk(1, 16'd3, 0, 0, 16'd0, 3));
    tbl.push_back(mk(1, 16'd1, 0, 0, 16'd0, 4));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 5));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 5));
    tbl.push_back(mk(0, 16'd0, 1, 1, 16'd1, 5));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 4));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 4));
    tbl.push_back(mk(0, 16'd0, 1, 1, 16'd3, 4));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 3));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 3));
    tbl.push_back(mk(0, 16'd0, 1, 1, 16'd3, 3));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 2));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 2));
    tbl.push_back(mk(0, 16'd0, 1, 1, 16'd7, 2));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 1));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 1));
    tbl.push_back(mk(0, 16'd0, 1, 1, 16'd9, 1));
    tbl.push_back(mk(0, 16'd0, 0, 0, 16'd0, 0));

    do_reset();
    chk("reset valid", out_valid, 0);
    chk("reset data", out_data, 0);
    chk("reset cnt", elem_cnt, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset ovf", err_ovf, 0);
    chk("reset udf", err_udf, 0);
    t_latency("lat");

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("tbl[%0d] valid", i), out_valid, tbl[i].x_valid);
      chk($sformatf("tbl[%0d] cnt", i), elem_cnt, tbl[i].x_cnt);
      chk($sformatf("tbl[%0d] empty", i), empty, tbl[i].x_cnt == 0);
      if (tbl[i].x_valid) chk($sformatf("tbl[%0d] data", i), out_data, tbl[i].x_data);
      enq = tbl[i].f_enq; inp_data = tbl[i].f_din; deq = tbl[i].f_deq;
      tick();
    end
    enq = 1'b0; deq = 1'b0;
    chk("tbl udf", err_udf, 0);

    // Swap in HOLD, then an equal key that must not swap.
    do_reset();
    push(16'h000A);
    wait_valid("swap first");
    chk("swap first data", out_data, 16'h000A);
    push(16'h0004);
    chk("swap data", out_data, 16'h0004);
    chk("swap valid", out_valid, 1);
    chk("swap cnt", elem_cnt, 2);
    push(16'h3704);
    chk("eqkey no swap", out_data, 16'h0004);
    chk("eqkey cnt", elem_cnt, 3);
    pop_expect("swap pop0", 16'h0004);
    pop_expect("swap pop1", 16'h3704);
    pop_expect("swap pop2", 16'h000A);
    chk("swap empty", empty, 1);

    // Simultaneous enq and deq in HOLD.
    do_reset();
    push(16'h0006);
    wait_valid("simul first");
    chk("simul head", out_data, 16'h0006);
    enq = 1'b1; deq = 1'b1; inp_data = 16'h0002;
    tick();
    enq = 1'b0; deq = 1'b0;
    chk("simul cnt", elem_cnt, 1);
    chk("simul valid", out_valid, 0);
    pop_expect("simul next", 16'h0002);

    // Only the low CMP_WID bits order entries.
    do_reset();
    push(16'hFF01);
    push(16'h0002);
    pop_expect("mask pop0", 16'hFF01);
    pop_expect("mask pop1", 16'h0002);

    // Capacity: 2 heaps x 3 + output register.
    do_reset();
    for (int k = 0; k < 6; k++) push(16'(20 + k));
    chk("heaps full in wait", full, 1);
    wait_valid("cap head");
    chk("cap hold not full", full, 0);
    chk("cap cnt6", elem_cnt, 6);
    push(16'd30);
    chk("cap full", full, 1);
    chk("cap cnt7", elem_cnt, 7);
    chk("cap ovf clear", err_ovf, 0);
    push(16'd40);
    chk("cap ovf", err_ovf, 1);
    chk("cap cnt after drop", elem_cnt, 7);
    chk("cap head kept", out_data, 16'd20);
    repeat (3) tick();
    chk("cap ovf sticky", err_ovf, 1);
    for (int k = 0; k < 6; k++) pop_expect($sformatf("cap pop%0d", k), 16'(20 + k));
    pop_expect("cap pop6", 16'd30);
    chk("cap empty", empty, 1);
    chk("cap ovf still", err_ovf, 1);
    do_reset();
    chk("cap ovf reset", err_ovf, 0);

    // Randomized traffic against a multiset model.
    begin
      logic [15:0] model[$];
      int idle;
      int mi, r;
      bit de, dq;
      logic [7:0] k;
      idle = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        chk("rnd cnt", elem_cnt, model.size());
        chk("rnd empty", empty, model.size() == 0);
        if (model.size() <= 3) chk("rnd full", full, 0);
        if (model.size() == 0) chk("rnd valid when empty", out_valid, 0);
        else if (idle >= LAT + 1) chk("rnd liveness", out_valid, 1);
        mi = min_idx(model);
        if (out_valid && mi >= 0) chk("rnd head", out_data, model[mi]);
        r  = $urandom_range(0, 9);
        de = (r < 3 || r == 9) && model.size() <= 3;
        dq = out_valid && mi >= 0 && ((r >= 3 && r < 6) || r == 9);
        k  = 8'($urandom_range(0, 255));
        enq = de; deq = dq; inp_data = {k ^ 8'hA5, k};
        if (dq) model.delete(mi);
        if (de) model.push_back({k ^ 8'hA5, k});
        idle = (de || dq) ? 0 : idle + 1;
        tick();
      end
      enq = 1'b0; deq = 1'b0;
      chk("rnd udf", err_udf, 0);
      chk("rnd ovf", err_ovf, 0);
    end

    // Underflow, then asynchronous reset while in WAIT.
    do_reset();
    deq = 1'b1; tick(); deq = 1'b0;
    chk("udf flag", err_udf, 1);
    chk("udf cnt", elem_cnt, 0);
    chk("udf valid", out_valid, 0);
    push(16'h0007);
    push(16'h0008);
    pop_expect("pre-reset head", 16'h0007);
    chk("pre-reset cnt", elem_cnt, 1);
    chk("pre-reset valid", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", out_valid, 0);
    chk("async data", out_data, 0);
    chk("async cnt", elem_cnt, 0);
    chk("async udf", err_udf, 0);
    chk("async ovf", err_ovf, 0);
    chk("async empty", empty, 1);
    tick();
    rst_n = 1'b1;
    t_latency("post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/prio_q_nway.md
PRIO_Q_NWAY -- requirements
Module: prio_q_nway

Interface
REQ-001 Parameter WIDTH, default 32: data width of enqueued and dequeued entries.
REQ-002 Parameter CMP_WID, default 32: only the CMP_WID LSBs are compared as the key; smaller key means higher priority.
REQ-003 Parameter DEPTH, default 8: depth of each pheap instance; per-heap capacity is 2^DEPTH-1.
REQ-004 Parameter NUM_HEAP, default 4: number of pheap instances; legal values are 2, 4 and 8.
REQ-005 Parameter HEAP_LAT, default 1: settle cycles between any pheap enq/deq and a valid pheap out_data; legal range is 1-7.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enq  in  1  enqueue request; accepted only when full=0.
REQ-009 inp_data  in  WIDTH  entry to enqueue.
REQ-010 deq  in  1  pop request; accepted only when out_valid=1.
REQ-011 out_data  out  WIDTH  registered global-minimum entry.
REQ-012 out_valid  out  1  out_data holds the current global minimum.
REQ-013 elem_cnt  out  DEPTH+4  total entries held: sum over all heaps plus out_valid.
REQ-014 full  out  1  no eligible heap can accept an enqueue this cycle.
REQ-015 empty  out  1  elem_cnt==0.
REQ-016 err_ovf  out  1  sticky flag: enq requested while full=1.
REQ-017 err_udf  out  1  sticky flag: deq requested while out_valid=0.

Function
REQ-018 The block SHALL instantiate NUM_HEAP pheap blocks sharing clk and rst_n, with at most one of enq/deq asserted per heap per cycle.
REQ-019 Enqueue target: the non-full heap with the smallest elem_cnt, excluding the heap being dequeued in PICK; ties go to the lowest index.
REQ-020 full SHALL be 1 when no heap qualifies under REQ-019; an enq while full=1 SHALL be dropped and SHALL set err_ovf.
REQ-021 Head select: among non-empty heaps, the smallest CMP_WID key; ties go to the lowest index.
REQ-022 FSM states: EMPTY, WAIT, PICK, HOLD; settle counter is 3 bits.
REQ-023 EMPTY: out_valid=0; an accepted enq SHALL move to WAIT with counter=HEAP_LAT.
REQ-024 WAIT: the counter decrements each cycle and reloads to HEAP_LAT on any heap enq/deq; at 0, go to PICK if any heap is non-empty, else to EMPTY.
REQ-025 PICK: SHALL capture the selected head into out_data, pulse deq to that heap, set out_valid, and go to HOLD.
REQ-026 HOLD, accepted deq: out_valid is cleared next cycle; go to WAIT (counter=HEAP_LAT) if any heap is non-empty, else to EMPTY.
REQ-027 HOLD, enq without deq, inp key < out_data key (swap): inp_data goes to out_data and the old out_data is written to the target heap; the FSM stays in HOLD.
REQ-028 HOLD, enq without deq, inp key >= out_data key: inp_data goes to the target heap; out_data is unchanged.
REQ-029 HOLD, simultaneous enq and deq: out_data is popped, inp_data goes to the target heap (no swap), then REQ-026 applies.
REQ-030 elem_cnt SHALL be a registered counter: +1 per accepted enq, -1 per accepted deq, unchanged when both occur, never wrapping.
REQ-031 Latency: an enq into an empty queue at cycle 0 SHALL give out_valid=1 at cycle HEAP_LAT+2.
REQ-032 Capacity: NUM_HEAP*(2^DEPTH-1)+1 entries including the output register.
REQ-033 A deq while out_valid=0 SHALL be ignored and SHALL set err_udf.

Reset
REQ-034 rst_n=0 SHALL immediately force FSM=EMPTY, out_valid=0, out_data=0, elem_cnt=0, counter=0, err_ovf=0 and err_udf=0, and reset all pheap instances.
REQ-035 Reset asserted mid-operation SHALL discard all contents; the first enq after release behaves as in REQ-031.

Verification
REQ-036 Reset, then enq 5 at cycle 0 with HEAP_LAT=1 -> out_valid=1 and out_data=5 at cycle 3; elem_cnt=1 from cycle 1.
REQ-037 Enq 9, 3, 7, 3, 1 back-to-back, then deq on every out_valid -> pops 1, 3, 3, 7, 9; empty=1 afterwards; err_udf=0.
REQ-038 Swap: in HOLD with out_data=10, enq 4 -> out_data=4 next cycle; a later deq yields 10; elem_cnt tracks correctly.
REQ-039 DEPTH=2, NUM_HEAP=2: after 7 enqs full=1 in HOLD; an 8th enq is dropped, err_ovf=1, elem_cnt=7; err_ovf stays 1 until reset.
REQ-040 Simultaneous enq 2 and deq in HOLD with out_data=6 -> 6 is popped, 2 is output next, elem_cnt unchanged.
REQ-041 deq with out_valid=0 -> err_udf=1 and elem_cnt unchanged; asserting rst_n=0 mid-WAIT clears all outputs asynchronously.
